// File: rtl/move_pkg.sv
// Shared types and helpers for the tic-tac-toe move issuer.
package move_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_CHECK,
    S_ISSUE,
    S_CONFIRM,
    S_ERROR
  } move_state_t;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P0    = 2'b01;
  localparam logic [1:0] CELL_P1    = 2'b10;
  localparam int         NUM_CELLS  = 9;

  // Out-of-range indices read as empty; callers range-check separately.
  function automatic logic [1:0] cell_of(input logic [17:0] cells, input logic [3:0] idx);
    logic [1:0] v;
    v = CELL_EMPTY;
    for (int i = 0; i < NUM_CELLS; i++)
      if (idx == 4'(i)) v = cells[2*i +: 2];
    return v;
  endfunction

endpackage

// File: rtl/first_empty_finder.sv
// Priority encoder: index of the lowest empty cell, plus a found flag.
module first_empty_finder
  import move_pkg::*;
(
  input  logic [17:0] cells,
  output logic [3:0]  idx,
  output logic        found
);

  // Scan high to low so the lowest empty cell wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = NUM_CELLS - 1; i >= 0; i--) begin
      if (cells[2*i +: 2] == CELL_EMPTY) begin
        idx   = 4'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/move_issuer.sv
// Select-bus initiator for the tic-tac-toe grid: validate, strobe, confirm, alternate turns.
// Define AUTO_MOVE_EN to auto-play the lowest empty cell after TIMEOUT_CYCLES idle cycles.
module move_issuer
  import move_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd250_000_000,
  parameter logic [2:0]  CONFIRM_MAX    = 3'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        move_valid,
  input  logic [3:0]  move_code,
  input  logic [17:0] cells,
  input  logic        game_over,
  output logic [3:0]  code,
  output logic        sel,
  output logic        pl,
  output logic        turn,
  output logic        move_ready,
  output logic        reject,
  output logic        timeout_pulse,
  output logic        board_full,
  output logic        err
);

  move_state_t state, state_nxt;
  logic [2:0]  ccnt;
  logic [3:0]  empty_idx;
  logic        empty_found;
  logic [1:0]  cur;
  logic        bad, cfm_ok, accept, auto_fire;

  first_empty_finder u_finder (
    .cells (cells),
    .idx   (empty_idx),
    .found (empty_found)
  );

  assign board_full = !empty_found;
  assign cur        = cell_of(cells, code);
  assign bad        = (code > 4'd8) || (cur != CELL_EMPTY);
  assign cfm_ok     = (cur == (pl ? CELL_P1 : CELL_P0));
  assign move_ready = (state == S_WAIT) && !game_over;
  assign sel        = (state == S_ISSUE);
  // A timeout in the same cycle wins over a request.
  assign accept     = move_valid && move_ready && !auto_fire;

`ifdef AUTO_MOVE_EN
  logic [31:0] timer;

  assign auto_fire = (state == S_WAIT) && !game_over && !board_full &&
                     (timer == TIMEOUT_CYCLES - 32'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer         <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= auto_fire;
      if (auto_fire || accept || (state == S_CONFIRM && cfm_ok))
        timer <= '0;
      else if (state == S_WAIT && !game_over && !board_full)
        timer <= timer + 32'd1;
    end
  end
`else
  assign auto_fire     = 1'b0;
  assign timeout_pulse = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:    if (auto_fire) state_nxt = S_ISSUE;
                 else if (accept) state_nxt = S_CHECK;
      S_CHECK:   state_nxt = bad ? S_WAIT : S_ISSUE;
      S_ISSUE:   state_nxt = S_CONFIRM;
      S_CONFIRM: if (cfm_ok) state_nxt = S_WAIT;
                 else if (ccnt == CONFIRM_MAX - 3'd1) state_nxt = S_ERROR;
      S_ERROR:   state_nxt = S_ERROR;
      default:   state_nxt = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_WAIT;
      code   <= '0;
      pl     <= 1'b0;
      turn   <= 1'b0;
      reject <= 1'b0;
      err    <= 1'b0;
      ccnt   <= '0;
    end else begin
      state  <= state_nxt;
      reject <= (state == S_CHECK) && bad;
      if (auto_fire)   code <= empty_idx;
      else if (accept) code <= move_code;
      if (state_nxt == S_ISSUE) pl <= turn;
      if (state == S_CONFIRM && cfm_ok) turn <= ~turn;
      ccnt <= (state == S_CONFIRM) ? ccnt + 3'd1 : 3'd0;
      if (state == S_CONFIRM && !cfm_ok && ccnt == CONFIRM_MAX - 3'd1) err <= 1'b1;
    end
  end

endmodule
